multicycle_adder: RTL and testbench
===================================

MULTICYCLE_ADDER -- requirements
Module: multicycle_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits.
REQ-002 SHALL have parameter CHUNK, default 4, bits added per clock cycle.
REQ-003 SHALL have port Clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port Reset  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port Start  input  1  request; sampled only in IDLE.
REQ-006 SHALL have port Sub  input  1  0 = A+B+Cin, 1 = A-B; latched on Start.
REQ-007 SHALL have port A  input  WIDTH  operand A; latched on Start.
REQ-008 SHALL have port B  input  WIDTH  operand B; latched on Start.
REQ-009 SHALL have port Cin  input  1  carry-in for add; ignored when Sub=1; latched on Start.
REQ-010 SHALL have port S  output  WIDTH  registered sum/difference.
REQ-011 SHALL have port Cout  output  1  carry out of bit WIDTH-1.
REQ-012 SHALL have port Overflow  output  1  two's-complement signed overflow.
REQ-013 SHALL have port Busy  output  1  high in RUN and DONE.
REQ-014 SHALL have port Done  output  1  one-cycle pulse; S/Cout/Overflow valid.

Function
REQ-015 SHALL implement states IDLE, RUN, DONE; NCHUNK = WIDTH/CHUNK.
REQ-016 SHALL transition IDLE->RUN on an edge with Start=1: latch A, B, Sub, Cin; chunk index := 0; carry := Sub ? 1 : Cin.
REQ-017 SHALL in RUN, each edge: add chunk [i*CHUNK +: CHUNK] of A and (Sub ? ~B : B) plus carry; write into S at that position; update carry; increment index.
REQ-018 SHALL process chunks LSB first; after the NCHUNK-th RUN edge go to DONE; RUN lasts exactly NCHUNK cycles.
REQ-019 SHALL on the DONE-entry edge register Cout = final carry and Overflow = (A[MSB]==B'[MSB]) && (S[MSB]!=A[MSB]), where B' = Sub ? ~B : B.
REQ-020 SHALL assert Done only in DONE; DONE->IDLE unconditionally on the next edge.
REQ-021 SHALL give latency: Start sampled at edge k -> Done high in the cycle after edge k+NCHUNK.
REQ-022 SHALL ignore Start in RUN and DONE; in-flight latched operands are unaffected by input changes.
REQ-023 SHALL hold S, Cout, Overflow stable from Done until the next accepted Start; S bits not yet written are unspecified during RUN.
REQ-024 SHALL support CHUNK == WIDTH (one RUN cycle); WIDTH % CHUNK != 0 is a fatal elaboration error.

Reset
REQ-025 SHALL on Reset=1, asynchronously: state := IDLE; S := 0; Cout, Overflow, Busy, Done := 0; index and carry := 0.
REQ-026 SHALL abort an operation in progress on Reset with no Done pulse; first Start after Reset deassertion is accepted normally.

Structure
REQ-027 SHALL place the state enum typedef in shared package adder_pkg.
REQ-028 SHALL use one sub-module, ripple_slice: combinational CHUNK-bit full-adder chain (a, b, cin -> s, cout), instantiated once.
REQ-029 SHALL keep datapath registers, index counter and FSM in multicycle_adder.

Verification (WIDTH=16, CHUNK=4 unless noted)
REQ-030 SHALL cover A=0x0055, B=0x0045, Cin=0, Sub=0, Start at edge k -> Done in cycle after edge k+4, S=0x009A, Cout=0, Overflow=0.
REQ-031 SHALL cover A=0xFFFF, B=0x0001, Cin=0 -> S=0x0000, Cout=1, Overflow=0; A=0x00F1, B=0x00BB, Cin=1 -> S=0x01AD.
REQ-032 SHALL cover Sub=1, A=0x8000, B=0x0001 -> S=0x7FFF, Cout=1, Overflow=1; Sub=1, A=0x0005, B=0x0005 -> S=0x0000, Cout=1.
REQ-033 SHALL cover Start held high throughout plus A/B changed mid-RUN -> result uses operands latched at Start; next op accepted only from IDLE.
REQ-034 SHALL cover Reset asserted in RUN cycle 2 -> outputs 0 immediately, no Done; new op afterwards gives correct result.
REQ-035 SHALL cover CHUNK=16: A=0x7FFF, B=0x0001 -> Done in cycle after edge k+1, S=0x8000, Overflow=1.

Source files
------------

// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared types and helpers for the multicycle adder
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of a counter that indexes n chunks; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ripple_slice.sv
// rtl/ripple_slice.sv - combinational W-bit ripple-carry full-adder chain
module ripple_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout
);

    logic [W:0] c;

    // Bit-serial carry chain from LSB to MSB of the slice.
    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < W; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[W];
    end

endmodule

// File: rtl/multicycle_adder.sv
// rtl/multicycle_adder.sv - add/subtract processed CHUNK bits per clock, LSB first
module multicycle_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Overflow,
    output logic             Busy,
    output logic             Done
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW     = idx_width(NCHUNK);
    localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

    if (WIDTH % CHUNK != 0) begin : g_width_check
        $fatal(1, "multicycle_adder: WIDTH must be a multiple of CHUNK");
    end

    state_t          state;
    state_t          state_nxt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;      // already inverted for subtraction
    logic            carry;
    logic [IW-1:0]   idx;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK-1:0] sum_chunk;
    logic            carry_out;
    logic            last_chunk;

    assign last_chunk = (idx == LAST_IDX);

    // Pick the operand chunks addressed by the current index.
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx == IW'(i)) begin
                a_chunk = a_q[i*CHUNK +: CHUNK];
                b_chunk = b_q[i*CHUNK +: CHUNK];
            end
        end
    end

    ripple_slice #(
        .W(CHUNK)
    ) u_slice (
        .a    (a_chunk),
        .b    (b_chunk),
        .cin  (carry),
        .s    (sum_chunk),
        .cout (carry_out)
    );

    // State register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and status outputs; Start is only looked at in IDLE.
    always_comb begin
        state_nxt = state;
        Busy      = 1'b0;
        Done      = 1'b0;
        case (state)
            IDLE: begin
                if (Start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                Busy = 1'b1;
                if (last_chunk) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                Busy      = 1'b1;
                Done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand latch, per-chunk result write-back and final flag capture.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            a_q      <= '0;
            b_q      <= '0;
            carry    <= 1'b0;
            idx      <= '0;
            S        <= '0;
            Cout     <= 1'b0;
            Overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        a_q   <= A;
                        b_q   <= Sub ? ~B : B;
                        carry <= Sub ? 1'b1 : Cin;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NCHUNK; i++) begin
                        if (idx == IW'(i)) begin
                            S[i*CHUNK +: CHUNK] <= sum_chunk;
                        end
                    end
                    carry <= carry_out;
                    if (last_chunk) begin
                        idx      <= '0;
                        Cout     <= carry_out;
                        // The last chunk holds the MSB, so its sum bit is the final S MSB.
                        Overflow <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                    (sum_chunk[CHUNK-1] != a_q[WIDTH-1]);
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_adder.sv
// tb/tb_multicycle_adder.sv - directed self-checking bench for multicycle_adder
module tb_multicycle_adder;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        start0;
    logic        start1;
    logic        Sub;
    logic        Cin;
    logic [15:0] A;
    logic [15:0] B;

    logic [15:0] s0;
    logic        cout0, ov0, busy0, done0;
    logic [15:0] s1;
    logic        cout1, ov1, busy1, done1;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 Clk = ~Clk;

    multicycle_adder #(.WIDTH(16), .CHUNK(4)) dut (
        .Clk(Clk), .Reset(Reset), .Start(start0), .Sub(Sub), .A(A), .B(B), .Cin(Cin),
        .S(s0), .Cout(cout0), .Overflow(ov0), .Busy(busy0), .Done(done0)
    );

    multicycle_adder #(.WIDTH(16), .CHUNK(16)) dut1 (
        .Clk(Clk), .Reset(Reset), .Start(start1), .Sub(Sub), .A(A), .B(B), .Cin(Cin),
        .S(s1), .Cout(cout1), .Overflow(ov1), .Busy(busy1), .Done(done1)
    );

    // Present operands at a falling edge and pulse Start across one rising edge.
    task automatic start_op(input bit which, input logic sub, input logic [15:0] a,
                            input logic [15:0] b, input logic cin);
        @(negedge Clk);
        Sub = sub; A = a; B = b; Cin = cin;
        if (which) start1 = 1'b1; else start0 = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    // Count rising edges until Done is seen; -1 if the budget runs out.
    task automatic wait_done(input bit which, input int budget, output int cyc);
        cyc = -1;
        for (int i = 1; i <= budget; i++) begin
            @(posedge Clk);
            @(negedge Clk);
            if ((which ? done1 : done0) === 1'b1) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        Reset = 1'b1; start0 = 0; start1 = 0; Sub = 0; Cin = 0; A = '0; B = '0;
        @(negedge Clk);
        n_cmp++; if (s0 !== 16'h0000) begin n_fail++; $display("FAIL reset_s: got %h want 0000", s0); end
        n_cmp++; if ({cout0, ov0, busy0, done0} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {cout0, ov0, busy0, done0}); end
        n_cmp++; if ({s1, cout1, ov1, busy1, done1} !== 20'h0) begin n_fail++; $display("FAIL reset_dut1: got %h want 0", {s1, cout1, ov1, busy1, done1}); end
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    task automatic test_add_basic;
        int cyc;
        start_op(0, 1'b0, 16'h0055, 16'h0045, 1'b0);
        n_cmp++; if (busy0 !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b want 1", busy0); end
        wait_done(0, 10, cyc);
        n_cmp++; if (cyc !== 4) begin n_fail++; $display("FAIL basic_latency: got %0d want 4", cyc); end
        n_cmp++; if (s0 !== 16'h009A) begin n_fail++; $display("FAIL basic_s: got %h want 009a", s0); end
        n_cmp++; if ({cout0, ov0} !== 2'b00) begin n_fail++; $display("FAIL basic_flags: got %b want 00", {cout0, ov0}); end
        @(posedge Clk);
        @(negedge Clk);
        n_cmp++; if ({busy0, done0} !== 2'b00) begin n_fail++; $display("FAIL basic_pulse: got %b want 00", {busy0, done0}); end
        @(negedge Clk);
        n_cmp++; if (s0 !== 16'h009A) begin n_fail++; $display("FAIL basic_hold: got %h want 009a", s0); end
    endtask

    task automatic test_add_carry;
        int cyc;
        start_op(0, 1'b0, 16'hFFFF, 16'h0001, 1'b0);
        wait_done(0, 10, cyc);
        n_cmp++; if (cyc !== 4) begin n_fail++; $display("FAIL wrap_latency: got %0d want 4", cyc); end
        n_cmp++; if ({s0, cout0, ov0} !== {16'h0000, 2'b10}) begin n_fail++; $display("FAIL wrap_result: got %h/%b%b want 0000/10", s0, cout0, ov0); end
        start_op(0, 1'b0, 16'h00F1, 16'h00BB, 1'b1);
        wait_done(0, 10, cyc);
        n_cmp++; if ({s0, cout0, ov0} !== {16'h01AD, 2'b00}) begin n_fail++; $display("FAIL cin_result: got %h/%b%b want 01ad/00", s0, cout0, ov0); end
    endtask

    task automatic test_sub;
        int cyc;
        start_op(0, 1'b1, 16'h8000, 16'h0001, 1'b0);
        wait_done(0, 10, cyc);
        n_cmp++; if ({s0, cout0, ov0} !== {16'h7FFF, 2'b11}) begin n_fail++; $display("FAIL sub_ovf: got %h/%b%b want 7fff/11", s0, cout0, ov0); end
        // Cin must be ignored when subtracting.
        start_op(0, 1'b1, 16'h0005, 16'h0005, 1'b1);
        wait_done(0, 10, cyc);
        n_cmp++; if ({s0, cout0, ov0} !== {16'h0000, 2'b10}) begin n_fail++; $display("FAIL sub_zero: got %h/%b%b want 0000/10", s0, cout0, ov0); end
    endtask

    task automatic test_start_held;
        int cyc;
        @(negedge Clk);
        Sub = 0; A = 16'h1234; B = 16'h0101; Cin = 0; start0 = 1'b1;
        @(posedge Clk);
        @(posedge Clk);
        @(negedge Clk);
        A = 16'hFFFF; B = 16'h0F0F;
        wait_done(0, 10, cyc);
        n_cmp++; if (cyc !== 3) begin n_fail++; $display("FAIL held_latency: got %0d want 3", cyc); end
        n_cmp++; if ({s0, cout0} !== {16'h1335, 1'b0}) begin n_fail++; $display("FAIL held_latched: got %h/%b want 1335/0", s0, cout0); end
        @(posedge Clk);
        @(negedge Clk);
        n_cmp++; if ({busy0, done0} !== 2'b00) begin n_fail++; $display("FAIL held_idle: got %b want 00", {busy0, done0}); end
        @(posedge Clk);
        @(negedge Clk);
        n_cmp++; if (busy0 !== 1'b1) begin n_fail++; $display("FAIL held_restart: got %b want 1", busy0); end
        start0 = 1'b0;
        wait_done(0, 10, cyc);
        n_cmp++; if (cyc !== 4) begin n_fail++; $display("FAIL held2_latency: got %0d want 4", cyc); end
        n_cmp++; if ({s0, cout0, ov0} !== {16'h0F0E, 2'b10}) begin n_fail++; $display("FAIL held2_result: got %h/%b%b want 0f0e/10", s0, cout0, ov0); end
    endtask

    task automatic test_reset_midrun;
        int cyc;
        int seen;
        start_op(0, 1'b0, 16'h4444, 16'h4444, 1'b0);
        @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        #1;
        n_cmp++; if ({s0, cout0, ov0, busy0, done0} !== 20'h0) begin n_fail++; $display("FAIL abort_clear: got %h want 0", {s0, cout0, ov0, busy0, done0}); end
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk);
            if (done0 === 1'b1 || busy0 === 1'b1) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d active cycles want 0", seen); end
        start_op(0, 1'b0, 16'h1111, 16'h2222, 1'b1);
        wait_done(0, 10, cyc);
        n_cmp++; if (cyc !== 4) begin n_fail++; $display("FAIL after_reset_latency: got %0d want 4", cyc); end
        n_cmp++; if (s0 !== 16'h3334) begin n_fail++; $display("FAIL after_reset_s: got %h want 3334", s0); end
    endtask

    task automatic test_chunk16;
        int cyc;
        start_op(1, 1'b0, 16'h7FFF, 16'h0001, 1'b0);
        wait_done(1, 5, cyc);
        n_cmp++; if (cyc !== 1) begin n_fail++; $display("FAIL c16_latency: got %0d want 1", cyc); end
        n_cmp++; if ({s1, cout1, ov1} !== {16'h8000, 2'b01}) begin n_fail++; $display("FAIL c16_result: got %h/%b%b want 8000/01", s1, cout1, ov1); end
    endtask

    initial begin
        test_reset();
        test_add_basic();
        test_add_carry();
        test_sub();
        test_start_held();
        test_reset_midrun();
        test_chunk16();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
